// File: rtl/uart_rx_frame_fsm.sv
// UART receive framing engine: synchronises the serial line, drives the external
// bit-period counter and turns one start/data/[parity]/stop frame into a parallel word.
module uart_rx_frame_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int BIT_CYCLES = 217,
    parameter int CNT_W      = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic [CNT_W-1:0]     cnt_value,
    input  logic                 cnt_flag,
    output logic                 cnt_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  MID      = CNT_W'(BIT_CYCLES / 2);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic                   sync_q;
    logic                   rx_s;
    logic                   rx_d;
    logic                   false_start;
    logic                   acc;
    logic                   par_bad;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift;

    logic fall;
    logic sample;
    logic boundary;

    // NOTE: the synchroniser presets to the idle-high line level so leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
            rx_d   <= 1'b1;
        end else begin
            sync_q <= rx_in;
            rx_s   <= sync_q;
            rx_d   <= rx_s;
        end
    end

    assign fall     = rx_d & ~rx_s;
    assign sample   = cnt_enable && (cnt_value == MID);
    assign boundary = cnt_enable && cnt_flag;

    // NOTE: all state and outputs are registered with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt_enable  <= 1'b0;
            busy        <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            false_start <= 1'b0;
            acc         <= 1'b0;
            par_bad     <= 1'b0;
            bit_idx     <= '0;
            shift       <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state       <= START;
                        cnt_enable  <= 1'b1;
                        busy        <= 1'b1;
                        false_start <= 1'b0;
                    end
                end
                START: begin
                    if (sample) false_start <= rx_s;
                    if (boundary) begin
                        if (false_start) begin
                            state      <= IDLE;
                            cnt_enable <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                            acc     <= 1'b0;
                            par_bad <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        acc   <= acc ^ rx_s;
                    end
                    if (boundary) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_IDX) state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (sample) par_bad <= ((acc ^ rx_s) != 1'(PARITY_ODD));
                    if (boundary) state <= STOP;
                end
                STOP: begin
                    // The word is published right after the stop-bit sample, long before the bit ends.
                    if (sample) begin
                        frame_err  <= ~rx_s;
                        rx_data    <= shift;
                        parity_err <= (PARITY_EN != 0) && par_bad;
                        rx_valid   <= 1'b1;
                    end
                    if (boundary) begin
                        state      <= IDLE;
                        cnt_enable <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt_enable <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_fsm.sv
// Bench for uart_rx_frame_fsm: an 8N1 instance and an 8E1 instance, each fed by a
// bench-side bit-period counter, checked cycle by cycle against a frame-level model.
module tb_uart_rx_frame_fsm;

    localparam int BC  = 217;
    localparam int LAT = (1 + 8) * BC + BC / 2 + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic rx_a  = 1'b1;
    logic rx_b  = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] cnt_a, cnt_b, data_a, data_b;
    logic flag_a, flag_b, en_a, en_b, valid_a, valid_b;
    logic perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

    assign flag_a = (cnt_a == 8'(BC - 1));
    assign flag_b = (cnt_b == 8'(BC - 1));

    always @(posedge clk or negedge reset) begin
        if (!reset) cnt_a <= 8'd0;
        else if (en_a) cnt_a <= flag_a ? 8'd0 : cnt_a + 8'd1;
    end
    always @(posedge clk or negedge reset) begin
        if (!reset) cnt_b <= 8'd0;
        else if (en_b) cnt_b <= flag_b ? 8'd0 : cnt_b + 8'd1;
    end

    uart_rx_frame_fsm #(.DATA_BITS(8), .BIT_CYCLES(BC), .CNT_W(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset(reset), .rx_in(rx_a), .cnt_value(cnt_a), .cnt_flag(flag_a),
        .cnt_enable(en_a), .rx_data(data_a), .rx_valid(valid_a), .parity_err(perr_a),
        .frame_err(ferr_a), .busy(busy_a));

    uart_rx_frame_fsm #(.DATA_BITS(8), .BIT_CYCLES(BC), .CNT_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .reset(reset), .rx_in(rx_b), .cnt_value(cnt_b), .cnt_flag(flag_b),
        .cnt_enable(en_b), .rx_data(data_b), .rx_valid(valid_b), .parity_err(perr_b),
        .frame_err(ferr_b), .busy(busy_b));

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Frame-level model: busy/enable window, valid cycle and the word each frame must deliver.
    int         en_lo[2]  = '{0, 0};
    int         en_hi[2]  = '{0, 0};
    int         v_cyc[2]  = '{-1, -1};
    logic [7:0] pend_data[2], hold_data[2];
    logic       pend_perr[2], pend_ferr[2], hold_perr[2], hold_ferr[2];
    int         vcnt[2]   = '{0, 0};
    int         rise_a    = 0;
    int         last_lat  = 0;
    logic       prev_en_a = 1'b0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            hold_data[i] = 8'h00; hold_perr[i] = 1'b0; hold_ferr[i] = 1'b0;
            pend_data[i] = 8'h00; pend_perr[i] = 1'b0; pend_ferr[i] = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                logic        en_exp, v_exp;
                logic [13:0] got, exp;
                en_exp = (cyc >= en_lo[i]) && (cyc < en_hi[i]);
                v_exp  = (cyc == v_cyc[i]);
                if (v_exp) begin
                    hold_data[i] = pend_data[i];
                    hold_perr[i] = pend_perr[i];
                    hold_ferr[i] = pend_ferr[i];
                end
                exp = {en_exp, en_exp, v_exp, hold_perr[i], hold_ferr[i], hold_data[i], 1'b0};
                if (i == 0) got = {en_a, busy_a, valid_a, perr_a, ferr_a, data_a, (!en_a && cnt_a != 8'd0)};
                else        got = {en_b, busy_b, valid_b, perr_b, ferr_b, data_b, (!en_b && cnt_b != 8'd0)};
                check($sformatf("dut%0d_cycle%0d", i, cyc), 32'(got), 32'(exp));
            end
            if (en_a && !prev_en_a) rise_a = cyc;
            if (valid_a) begin
                last_lat = cyc - rise_a;
                vcnt[0]++;
            end
            if (valid_b) vcnt[1]++;
            prev_en_a = en_a;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int i, input logic v);
        if (i == 0) rx_a = v;
        else        rx_b = v;
    endtask

    // bits[0] is the start bit; n line bits make up the frame, only ndrive of them are driven.
    task automatic send(input int i, input logic [11:0] bits, input int n, input int ndrive);
        int s;
        s        = cyc;
        en_lo[i] = s + 3;
        en_hi[i] = s + 3 + n * BC;
        v_cyc[i] = s + 3 + (n - 1) * BC + BC / 2 + 1;
        pend_data[i] = bits[8:1];
        pend_ferr[i] = ~bits[n-1];
        pend_perr[i] = (i == 1) ? (^bits[9:1]) : 1'b0;
        for (int b = 0; b < ndrive; b++) begin
            set_line(i, bits[b]);
            wait_cyc(BC);
        end
    endtask

    task automatic idle(input int i, input int n);
        set_line(i, 1'b1);
        wait_cyc(n);
    endtask

    task automatic glitch(input int i, input int low);
        int s;
        s        = cyc;
        en_lo[i] = s + 3;
        en_hi[i] = s + 3 + BC;
        v_cyc[i] = -1;
        set_line(i, 1'b0);
        wait_cyc(low);
        set_line(i, 1'b1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            en_lo[i] = 0; en_hi[i] = 0; v_cyc[i] = -1;
            hold_data[i] = 8'h00; hold_perr[i] = 1'b0; hold_ferr[i] = 1'b0;
        end
    endtask

    function automatic logic [11:0] frame8(input logic [7:0] d, input logic stop);
        return {3'b000, stop, d, 1'b0};
    endfunction

    function automatic logic [11:0] framep(input logic [7:0] d, input logic p, input logic stop);
        return {2'b00, stop, p, d, 1'b0};
    endfunction

    initial begin
        int vc;
        wait_cyc(2);
        check("reset_outputs_a", 32'({en_a, busy_a, valid_a, perr_a, ferr_a, data_a}), 32'd0);
        reset = 1'b1;
        wait_cyc(10);

        send(0, frame8(8'hA5, 1'b1), 10, 10);
        idle(0, BC);
        check("a5_data", 32'(data_a), 32'h0000_00A5);
        check("a5_latency", 32'(last_lat), 32'd2062);
        check("a5_valid_count", 32'(vcnt[0]), 32'd1);
        check("a5_errors", 32'({perr_a, ferr_a}), 32'd0);

        send(0, frame8(8'h00, 1'b1), 10, 10);
        idle(0, BC);
        send(0, frame8(8'hFF, 1'b1), 10, 10);
        idle(0, BC);
        send(0, frame8(8'h3C, 1'b1), 10, 10);
        idle(0, BC);
        check("b2b_valid_count", 32'(vcnt[0]), 32'd4);
        check("b2b_last_data", 32'(data_a), 32'h0000_003C);

        glitch(0, 50);
        wait_cyc(BC);
        check("glitch_busy_low", 32'(busy_a), 32'd0);
        check("glitch_no_valid", 32'(vcnt[0]), 32'd4);
        send(0, frame8(8'h81, 1'b1), 10, 10);
        idle(0, BC);
        check("after_glitch_data", 32'(data_a), 32'h0000_0081);

        send(0, frame8(8'h55, 1'b0), 10, 10);
        idle(0, BC);
        check("bad_stop_ferr", 32'({data_a, ferr_a}), 32'({8'h55, 1'b1}));
        send(0, frame8(8'h96, 1'b1), 10, 10);
        idle(0, BC);
        check("clean_clears_ferr", 32'({data_a, ferr_a}), 32'({8'h96, 1'b0}));

        vc = vcnt[0];
        send(0, 12'h000, 10, 10);
        wait_cyc(3 * BC);
        check("break_one_frame", 32'(vcnt[0] - vc), 32'd1);
        check("break_word", 32'({data_a, ferr_a, busy_a}), 32'({8'h00, 1'b1, 1'b0}));
        idle(0, BC);

        send(1, framep(8'h07, 1'b1, 1'b1), 11, 11);
        idle(1, BC);
        check("par_ok", 32'({data_b, perr_b, ferr_b}), 32'({8'h07, 1'b0, 1'b0}));
        send(1, framep(8'h07, 1'b0, 1'b1), 11, 11);
        idle(1, BC);
        check("par_bad", 32'({data_b, perr_b, ferr_b}), 32'({8'h07, 1'b1, 1'b0}));

        vc = vcnt[0];
        send(0, frame8(8'hE7, 1'b1), 10, 5);
        wait_cyc(100);
        reset = 1'b0;
        clear_model();
        set_line(0, 1'b1);
        wait_cyc(1);
        check("reset_mid_a", 32'({en_a, busy_a, valid_a, perr_a, ferr_a, data_a}), 32'd0);
        check("reset_mid_b", 32'({en_b, busy_b, perr_b, data_b}), 32'd0);
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(BC);
        check("reset_no_valid", 32'(vcnt[0] - vc), 32'd0);
        send(0, frame8(8'hC3, 1'b1), 10, 10);
        idle(0, BC);
        check("after_reset_data", 32'({data_a, perr_a, ferr_a}), 32'({8'hC3, 2'b00}));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
